regfile_wb_sched: RTL

Write-back scheduler for the 32x32 register file. Shares the single register-file write port between NREQ write-back requesters with round-robin arbitration. Keeps a per-register busy scoreboard so the issue stage can detect RAW hazards on rs1/rs2 and WAW hazards on rd. Sits between the execute/load units and the register file, and drives its `regwrite`/`rd`/`writedata` inputs directly.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its write-back scheduler.
// Holds the architectural register count, index/data widths and the
// matching convenience types so every block agrees on them.
package regfile_pkg;

  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int DW    = 32;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request found when scanning upward from ptr,
// wrapping past N-1 back to 0. The pointer itself is owned by the parent.
// Ports:
//   req     : request vector, one bit per requester
//   ptr     : requester index with highest priority this cycle
//   grant   : one-hot grant (all zero when no request is asserted)
//   gnt_idx : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gnt_idx
);

  int idx;

  // Walk the priority offsets from the farthest back to the nearest, so the
  // last hit overwritten into grant/gnt_idx is the one closest to ptr. This
  // keeps the grant one-hot without a separate "already found" flag.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[PW'(idx)]) begin
        grant            = '0;
        grant[PW'(idx)]  = 1'b1;
        gnt_idx          = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file.
// Shares the single register-file write port between NREQ requesters with
// round-robin arbitration, registers the winning write into the register
// file's write port, and tracks a per-register busy scoreboard so issue can
// stall on RAW (hazard) and WAW (rsv_ready) conflicts.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/ready     : per-requester handshake (ready is one-hot or zero)
//   req_rd/req_data     : per-requester destination register and data
//   rsv_valid/rd/ready  : issue-stage reservation of a destination register
//   rs1, rs2, hazard    : source registers in issue and their stall flag
//   rf_regwrite/rd/writedata : register-file write port
module regfile_wb_sched #(
  parameter int NREQ  = 3,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][AW-1:0]   req_rd,
  input  logic [NREQ-1:0][DW-1:0]   req_data,
  input  logic                      rsv_valid,
  input  logic [AW-1:0]             rsv_rd,
  output logic                      rsv_ready,
  input  logic [AW-1:0]             rs1,
  input  logic [AW-1:0]             rs2,
  output logic                      hazard,
  output logic                      rf_regwrite,
  output logic [AW-1:0]             rf_rd,
  output logic [DW-1:0]             rf_writedata
);

  import regfile_pkg::*;

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_idx;
  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [AW-1:0]    xfer_rd;
  logic [DW-1:0]    xfer_data;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             rsv_take;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .gnt_idx(gnt_idx)
  );

  // The grant is only exposed while out of reset; the arbiter's grant only
  // ever covers valid requesters, so any grant bit is also a transfer.
  assign req_ready = rst_n ? grant : '0;
  assign xfer      = |req_ready;
  assign xfer_rd   = req_rd[gnt_idx];
  assign xfer_data = req_data[gnt_idx];

  // A reservation for a busy register is refused, which stalls WAW. x0 is
  // never busy so it is always accepted and never marked.
  assign rsv_ready = !busy[rsv_rd];
  assign rsv_take  = rsv_valid && rsv_ready && (rsv_rd != '0);

  // Stall issue while a source is still owed a write, and for one more
  // cycle while that write is sitting on the register-file port: the file
  // only holds the new value after the following edge.
  assign hazard = busy[rs1] | busy[rs2] |
                  (rf_regwrite && ((rf_rd == rs1) || (rf_rd == rs2)));

  // Scoreboard next state: clear for the accepted write first, then apply a
  // new reservation so that a same-edge set/clear leaves the register busy.
  always_comb begin
    busy_nxt = busy;
    if (xfer) begin
      busy_nxt[xfer_rd] = 1'b0;
    end
    if (rsv_take) begin
      busy_nxt[rsv_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Round-robin pointer moves just past the winner on every transfer, which
  // gives each requester a turn at least once every NREQ accepted writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Write stage: the accepted request drives the register-file port for one
  // cycle. Writes to x0 are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_regwrite  <= 1'b0;
      rf_rd        <= '0;
      rf_writedata <= '0;
    end else if (xfer) begin
      rf_regwrite  <= (xfer_rd != '0);
      rf_rd        <= xfer_rd;
      rf_writedata <= xfer_data;
    end else begin
      rf_regwrite  <= 1'b0;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule
